// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM with async fetch/load ports, store FIFO drained on load-free cycles
// Optional: define IFETCH_SNOOP_EN to let instruction fetch forward from the store buffer.
module mem_responder #(
    parameter int W         = 32,
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    output logic [W-1:0] inst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         stall,
    output logic         sb_empty
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(SB_DEPTH);

    logic [W-1:0]  mem     [MEM_WORDS];
    logic [IW-1:0] sb_idx  [SB_DEPTH];
    logic [W-1:0]  sb_data [SB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [IW-1:0] pc_idx;
    logic [IW-1:0] l_idx;
    logic [IW-1:0] s_idx;
    logic          unused_addr;

    assign pc_idx = pc[IW+1:2];
    assign l_idx  = l_addr[IW+1:2];
    assign s_idx  = s_addr[IW+1:2];
    assign unused_addr = ^{pc[1:0], pc[W-1:IW+2], l_addr[1:0], l_addr[W-1:IW+2],
                           s_addr[1:0], s_addr[W-1:IW+2]};

    logic          full;
    logic          empty;
    logic          drain;
    logic          direct;
    logic          enq;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_data;

    assign full     = (count == FULL);
    assign empty    = (count == '0);
    assign stall    = full;
    assign sb_empty = empty;

    // RAM write port is free only when no load is using the cycle
    assign drain  = !load_en && !empty;
    assign direct = store_en && !load_en && empty;
    assign enq    = store_en && !direct && (!full || drain);

    assign wr_en   = direct || drain;
    assign wr_idx  = direct ? s_idx  : sb_idx[head];
    assign wr_data = direct ? s_data : sb_data[head];

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                sb_idx[tail]  <= s_idx;
                sb_data[tail] <= s_data;
                tail          <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    // Walk oldest to youngest so the last match, the youngest store, wins
    always_comb begin
        logic [PW-1:0] pos;
        l_data = '0;
        pos    = '0;
        if (load_en) begin
            l_data = mem[l_idx];
            for (int k = 0; k < SB_DEPTH; k++) begin
                pos = head + PW'(k);
                if ((CW'(k) < count) && (sb_idx[pos] == l_idx)) begin
                    l_data = sb_data[pos];
                end
            end
        end
    end

`ifdef IFETCH_SNOOP_EN
    always_comb begin
        logic [PW-1:0] pos;
        inst = mem[pc_idx];
        pos  = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            pos = head + PW'(k);
            if ((CW'(k) < count) && (sb_idx[pos] == pc_idx)) begin
                inst = sb_data[pos];
            end
        end
    end
`else
    assign inst = mem[pc_idx];
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        load_en;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic        store_en;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic        stall;
    logic        sb_empty;

    int vectors = 0;
    int errors  = 0;

    mem_responder #(.W(32), .MEM_WORDS(1024), .SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst),
        .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
        .store_en(store_en), .s_addr(s_addr), .s_data(s_data),
        .stall(stall), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        load_en = 1'b1;
        l_addr  = a;
        #1;
        check(tag, l_data, exp);
    endtask

    task automatic store(input logic le, input logic [31:0] a, input logic [31:0] d);
        load_en  = le;
        store_en = 1'b1;
        s_addr   = a;
        s_data   = d;
        tick();
        store_en = 1'b0;
    endtask

    task automatic drain_n(input int n);
        load_en  = 1'b0;
        store_en = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; pc = '0; load_en = 1'b0; l_addr = '0;
        store_en = 1'b0; s_addr = '0; s_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_empty", {31'b0, sb_empty}, 32'd1);

        // Preload known RAM values through direct writes
        store(1'b0, 32'h0C, 32'h0000C0C0);
        store(1'b0, 32'h30, 32'h00000007);
        store(1'b0, 32'h00, 32'h000000A0);
        store(1'b0, 32'h40, 32'h00004040);
        store(1'b0, 32'h70, 32'h00000700);
        store(1'b0, 32'h74, 32'h00000740);
        store(1'b0, 32'h78, 32'h00000780);

        // 1: direct write then load
        store(1'b0, 32'h10, 32'hDEADBEEF);
        load_chk("t1_load", 32'h10, 32'hDEADBEEF);
        check("t1_empty", {31'b0, sb_empty}, 32'd1);
        load_chk("t1_wrap", 32'h1013, 32'hDEADBEEF);
        load_en = 1'b0;
        #1;
        check("t1_noload_zero", l_data, 32'd0);

        // 2: fill buffer while a load holds the write port
        l_addr = 32'h40;
        store(1'b1, 32'h0, 32'h11);
        check("t2_nonempty", {31'b0, sb_empty}, 32'd0);
        check("t2_l40", l_data, 32'h4040);
        store(1'b1, 32'h4, 32'h22);
        store(1'b1, 32'h8, 32'h33);
        check("t2_stall3", {31'b0, stall}, 32'd0);
        store(1'b1, 32'h0, 32'h44);
        check("t2_stall4", {31'b0, stall}, 32'd1);
        load_chk("t2_fwd_young", 32'h0, 32'h44);
        load_chk("t2_fwd_8", 32'h8, 32'h33);
        load_chk("t2_fwd_4", 32'h4, 32'h22);
        pc = 32'h0;
        #1;
`ifdef IFETCH_SNOOP_EN
        check("t2_fetch", inst, 32'h44);
`else
        check("t2_fetch", inst, 32'hA0);
`endif

        // 3: refused store while full, then drain
        store(1'b1, 32'hC, 32'h55);
        check("t3_stall_held", {31'b0, stall}, 32'd1);
        load_chk("t3_c_old", 32'hC, 32'hC0C0);
        drain_n(3);
        check("t3_empty3", {31'b0, sb_empty}, 32'd0);
        drain_n(1);
        check("t3_empty4", {31'b0, sb_empty}, 32'd1);
        check("t3_stall0", {31'b0, stall}, 32'd0);
        pc = 32'h0;
        #1;
        check("t3_ram0", inst, 32'h44);
        pc = 32'h8;
        #1;
        check("t3_ram8", inst, 32'h33);
        load_chk("t3_c_final", 32'hC, 32'hC0C0);

        // 4: full, drain and enqueue in one edge
        store(1'b1, 32'h50, 32'h1);
        store(1'b1, 32'h54, 32'h2);
        store(1'b1, 32'h58, 32'h3);
        store(1'b1, 32'h5C, 32'h4);
        check("t4_full", {31'b0, stall}, 32'd1);
        store(1'b0, 32'h20, 32'h66);
        check("t4_still_full", {31'b0, stall}, 32'd1);
        drain_n(4);
        check("t4_empty", {31'b0, sb_empty}, 32'd1);
        load_chk("t4_20", 32'h20, 32'h66);
        load_chk("t4_50", 32'h50, 32'h1);
        load_chk("t4_5c", 32'h5C, 32'h4);

        // 5: same-cycle load/store is not forwarded
        store(1'b1, 32'h60, 32'h99);
        load_en = 1'b1; l_addr = 32'h30;
        store_en = 1'b1; s_addr = 32'h30; s_data = 32'h77;
        #1;
        check("t5_same_cycle", l_data, 32'h7);
        tick();
        store_en = 1'b0;
        #1;
        check("t5_next_cycle", l_data, 32'h77);
        drain_n(2);
        check("t5_empty", {31'b0, sb_empty}, 32'd1);
        load_chk("t5_ram30", 32'h30, 32'h77);

        // 6: reset discards buffered stores, including the in-flight drain
        l_addr = 32'h0;
        store(1'b1, 32'h70, 32'hAAAA);
        store(1'b1, 32'h74, 32'hBBBB);
        store(1'b1, 32'h78, 32'hCCCC);
        load_chk("t6_fwd74", 32'h74, 32'hBBBB);
        pc = 32'h70;
        #1;
`ifdef IFETCH_SNOOP_EN
        check("t6_fetch_snoop", inst, 32'hAAAA);
`else
        check("t6_fetch_snoop", inst, 32'h700);
`endif
        load_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_empty", {31'b0, sb_empty}, 32'd1);
        check("t6_stall", {31'b0, stall}, 32'd0);
        load_chk("t6_70", 32'h70, 32'h700);
        load_chk("t6_74", 32'h74, 32'h740);
        load_chk("t6_78", 32'h78, 32'h780);

        // Fetch sees the store once it has drained
        store(1'b1, 32'h70, 32'hBEEF);
        drain_n(1);
        pc = 32'h70;
        #1;
        check("t6_fetch_drained", inst, 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's fetch and load/store interface: serves `pc`→`inst`, `load_en`/`l_addr`→`l_data`, and accepts `store_en`/`s_addr`/`s_data`.
- Word-organised RAM with two asynchronous read ports (fetch, load) and one synchronous write port.
- The write port is fed by a small FIFO store buffer that drains only in cycles with no load.
- Loads forward from the store buffer. Buffer-full is reported as `stall`.

Parameters:
- W, 32: data/address width.
- MEM_WORDS, 1024: RAM depth in words; power of two.
- SB_DEPTH, 4: store-buffer entries; power of two, ≥2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- pc  input  W  fetch byte address.
- inst  output  W  fetched word.
- load_en  input  1  load request this cycle.
- l_addr  input  W  load byte address.
- l_data  output  W  load data.
- store_en  input  1  store request this cycle.
- s_addr  input  W  store byte address.
- s_data  input  W  store data.
- stall  output  1  store buffer full; a store this cycle may be refused.
- sb_empty  output  1  no pending stores; usable as a fence.

Behaviour:
- Reset and clocking:
  - One clock `clk`. Reset `rst` is synchronous and active-high.
  - On reset: count=0, head=tail=0, all pending stores discarded, stall=0, sb_empty=1.
  - RAM contents are not cleared.
  - Reset mid-drain: the write in the reset cycle is suppressed.
- Addressing:
  - Word index = addr[log2(MEM_WORDS)+1:2].
  - addr[1:0] is ignored; upper bits are ignored, so addresses wrap modulo MEM_WORDS words.
- Fetch:
  - inst = RAM[idx(pc)], combinational, zero latency.
  - Fetch does not see buffered stores (see optional feature).
- Load:
  - l_data combinational, zero latency.
  - If load_en=0, l_data=0.
  - Otherwise l_data = data of the youngest valid buffer entry whose index matches idx(l_addr), else RAM[idx(l_addr)].
  - A store presented in the same cycle is NOT forwarded; the load sees pre-edge state.
- Store buffer:
  - Circular FIFO of {word index, data}, with head, tail and count (count width log2(SB_DEPTH)+1).
  - Pointers wrap modulo SB_DEPTH.
  - Outputs: stall = (count==SB_DEPTH); sb_empty = (count==0).
- Per-cycle actions at the clock edge, by case:
  - Direct write (count==0, store_en=1, load_en=0): RAM[idx(s_addr)]<=s_data; buffer untouched.
  - Enqueue (store_en=1, count<SB_DEPTH, not the direct-write case): entry written at tail, tail+1.
  - Drain (load_en=0, count>0): RAM[head entry]<=data, head+1.
  - Full, drain and store together (count==SB_DEPTH, load_en=0, store_en=1): drain and enqueue in the same edge; count unchanged; the store is accepted.
  - Full, store refused (count==SB_DEPTH, load_en=1, store_en=1): store dropped, no state change. The requester holds the store until stall=0.
  - Count update: count += enqueue − drain.
- Ordering: stores reach RAM in program order. Duplicate addresses in the buffer are legal; the youngest matching entry wins for forwarding.

Optional Feature:
- Macro: `IFETCH_SNOOP_EN`.
- When defined: inst uses the same forwarding as loads. inst = youngest matching buffer entry for idx(pc), else RAM. This supports self-modifying code.
- When undefined: inst reads RAM only. Software must wait for sb_empty=1 before fetching freshly stored code.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x10 with load_en=0 and an empty buffer → direct write. Next cycle, load 0x10 returns 0xDEADBEEF and sb_empty stays 1.
2. Hold load_en=1 (l_addr=0x40) while storing 0x11,0x22,0x33,0x44 to 0x0,0x4,0x8,0x0 →
   - count reaches 4 and stall=1.
   - A load of 0x0 returns 0x44 (youngest entry); a load of 0x8 returns 0x33.
3. From the full state of (2), keep load_en=1 and present a 5th store 0x55 to 0xC → dropped: count stays 4 and 0xC later reads its old value. Then drop load_en → 4 cycles of drain, RAM[0]=0x44, sb_empty=1.
4. Full buffer, load_en=0, store 0x66 to 0x20 → drain and enqueue in the same edge: count stays 4, stall stays 1, and after a full drain 0x20 reads 0x66.
5. Same-cycle load and store to 0x30 (old value 0x7) with buffer non-empty → l_data=0x7 that cycle; the next cycle's load returns the new data.
6. Three stores buffered, then rst=1 for 1 cycle → count=0, sb_empty=1, and the RAM is unchanged at all three addresses. With `IFETCH_SNOOP_EN`: a store to pc's address while buffered makes inst reflect the new value immediately.
